mem_stage: RTL and testbench

- Memory stage of the 5-stage 16-bit pipeline. It consumes the execute stage's results (ALU result, store data, control bits, M-to-M forward select) through an internal X/M pipeline register.
- Performs data-memory loads and stores over a req/ack handshake that may take several cycles.
- Stalls upstream while an access is outstanding.
- Drives the M/W pipeline register plus the X/M and M/W forwarding taps used by the execute stage's hazard logic.

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/dmem_if_fsm.sv | 38 +++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: widths, dmem FSM state encoding and
// the halfword address alignment mask.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [15:0] ADDR_MASK = 16'hFFFE;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory handshake controller: IDLE/ACCESS state, request/write-enable
// generation and the upstream stall.
module dmem_if_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic is_store,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic dmem_we,
  output logic stall_out
);

  mem_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mem_op && !dmem_ack) state <= ACCESS;
        ACCESS:  if (dmem_ack || !mem_op) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The request is raised in the same cycle the op appears in X/M; because X/M
  // holds while stalled, request, address and data stay stable through ACCESS.
  always_comb begin
    dmem_req  = mem_op && (state == IDLE || state == ACCESS);
    dmem_we   = dmem_req && is_store;
    stall_out = dmem_req && !dmem_ack;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage 16-bit pipeline: X/M and M/W registers, data
// memory access muxing and forwarding taps. `define MEM_STALL_CNT_EN adds a
// saturating stall-cycle counter.
module mem_stage #(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_W  = mem_stage_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_dst_reg,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              ex_b_m2m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] xm_alu_out,
  output logic              xm_reg_write,
  output logic [REG_W-1:0]  xm_dst_reg,
  output logic [REG_W-1:0]  xm_rt,
  output logic              mw_valid,
  output logic              mw_reg_write,
  output logic [REG_W-1:0]  mw_dst_reg,
  output logic [DATA_W-1:0] mw_data
`ifdef MEM_STALL_CNT_EN
  ,
  input  logic              mem_stall_cnt_clr,
  output logic [15:0]       mem_stall_cnt
`endif
);

  import mem_stage_pkg::*;

  logic              xm_valid;
  logic              xm_mem_read;
  logic              xm_mem_write;
  logic              xm_b_m2m;
  logic [DATA_W-1:0] xm_store_data;

  logic mem_op;
  logic is_store;
  logic is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      xm_valid      <= 1'b0;
      xm_alu_out    <= '0;
      xm_store_data <= '0;
      xm_mem_read   <= 1'b0;
      xm_mem_write  <= 1'b0;
      xm_reg_write  <= 1'b0;
      xm_dst_reg    <= '0;
      xm_rt         <= '0;
      xm_b_m2m      <= 1'b0;
    end else if (!stall_out) begin
      xm_valid      <= ex_valid;
      xm_alu_out    <= ex_alu_out;
      xm_store_data <= ex_store_data;
      xm_mem_read   <= ex_mem_read;
      xm_mem_write  <= ex_mem_write;
      xm_reg_write  <= ex_reg_write;
      xm_dst_reg    <= ex_dst_reg;
      xm_rt         <= ex_rt;
      xm_b_m2m      <= ex_b_m2m;
    end
  end

  // Read+write together resolves to a store.
  assign mem_op   = xm_valid && (xm_mem_read || xm_mem_write);
  assign is_store = xm_mem_write;
  assign is_load  = xm_mem_read && !xm_mem_write;

  dmem_if_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (mem_op),
    .is_store  (is_store),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .stall_out (stall_out)
  );

  assign dmem_addr  = xm_alu_out & ADDR_MASK;
  assign dmem_wdata = xm_b_m2m ? mw_data : xm_store_data;

  // M/W holds (no bubble) during a stall so M-to-M store data stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mw_valid     <= 1'b0;
      mw_reg_write <= 1'b0;
      mw_dst_reg   <= '0;
      mw_data      <= '0;
    end else if (!stall_out) begin
      mw_valid     <= xm_valid;
      mw_reg_write <= xm_valid && xm_reg_write && !is_store;
      mw_dst_reg   <= xm_dst_reg;
      mw_data      <= (xm_valid && is_load) ? dmem_rdata : xm_alu_out;
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || mem_stall_cnt_clr) begin
      mem_stall_cnt <= '0;
    end else if (stall_out && mem_stall_cnt != 16'hFFFF) begin
      mem_stall_cnt <= mem_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a random stream
// checked against a transaction-level model of the stage and data memory.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_b_m2m;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [3:0]  ex_dst_reg, ex_rt;
  logic        dmem_req, dmem_we, dmem_ack, stall_out;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] xm_alu_out, mw_data;
  logic        xm_reg_write, mw_valid, mw_reg_write;
  logic [3:0]  xm_dst_reg, xm_rt, mw_dst_reg;
`ifdef MEM_STALL_CNT_EN
  logic        mem_stall_cnt_clr;
  logic [15:0] mem_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_dst_reg(ex_dst_reg), .ex_rt(ex_rt), .ex_b_m2m(ex_b_m2m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .xm_alu_out(xm_alu_out), .xm_reg_write(xm_reg_write), .xm_dst_reg(xm_dst_reg), .xm_rt(xm_rt),
    .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_dst_reg(mw_dst_reg), .mw_data(mw_data)
`ifdef MEM_STALL_CNT_EN
    , .mem_stall_cnt_clr(mem_stall_cnt_clr), .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    logic        rd, wr, rw, m2m;
    logic [3:0]  dst, rt;
    int unsigned lat;
  } instr_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned dut_stalls = 0;

  instr_t      prog[$];
  instr_t      cur;
  logic [15:0] env_mem[128];
  logic [15:0] ref_mem[128];
  logic        exp_mw_valid, exp_mw_rw;
  logic [3:0]  exp_mw_dst;
  logic [15:0] exp_mw_data;
  int unsigned req_cycles;
  logic        gen_last_valid = 1'b0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic instr_t garbage();
    instr_t i;
    i.valid = 1'($urandom); i.alu = 16'($urandom); i.sd = 16'($urandom);
    i.rd = 1'($urandom); i.wr = 1'($urandom); i.rw = 1'($urandom); i.m2m = 1'($urandom);
    i.dst = 4'($urandom); i.rt = 4'($urandom); i.lat = 1;
    return i;
  endfunction

  function automatic instr_t bubble();
    instr_t i = garbage();
    i.valid = 1'b0;
    return i;
  endfunction

  function automatic instr_t mk(input logic rd, input logic wr, input logic [15:0] alu,
                                input logic [15:0] sd, input logic rw, input logic [3:0] dst,
                                input logic [3:0] rt, input logic m2m, input int unsigned lat);
    instr_t i;
    i.valid = 1'b1; i.rd = rd; i.wr = wr; i.alu = alu; i.sd = sd; i.rw = rw;
    i.dst = dst; i.rt = rt; i.m2m = m2m; i.lat = lat;
    return i;
  endfunction

  // M-to-M stores only follow a valid instruction, since bubble data is unspecified.
  function automatic instr_t rand_instr();
    instr_t i = garbage();
    i.valid = ($urandom_range(0, 7) != 0);
    i.alu = 16'($urandom_range(0, 255));
    case ($urandom_range(0, 7))
      0, 1, 2: begin i.rd = 1'b0; i.wr = 1'b0; end
      3, 4:    begin i.rd = 1'b1; i.wr = 1'b0; end
      5, 6:    begin i.rd = 1'b0; i.wr = 1'b1; end
      default: begin i.rd = 1'b1; i.wr = 1'b1; end
    endcase
    if (!gen_last_valid) i.m2m = 1'b0;
    i.lat = $urandom_range(1, 4);
    gen_last_valid = i.valid;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_valid = i.valid; ex_alu_out = i.alu; ex_store_data = i.sd;
    ex_mem_read = i.rd; ex_mem_write = i.wr; ex_reg_write = i.rw;
    ex_dst_reg = i.dst; ex_rt = i.rt; ex_b_m2m = i.m2m;
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cycle();
    logic        mem_op, is_ld, ack, exp_stall;
    logic [15:0] eaddr, ewdata;
    chk1("mw_valid", mw_valid, exp_mw_valid);
    chk1("mw_reg_write", mw_reg_write, exp_mw_rw);
    if (exp_mw_valid) begin
      chk4("mw_dst_reg", mw_dst_reg, exp_mw_dst);
      chk16("mw_data", mw_data, exp_mw_data);
    end
    chk16("xm_alu_out", xm_alu_out, cur.alu);
    chk4("xm_dst_reg", xm_dst_reg, cur.dst);
    chk4("xm_rt", xm_rt, cur.rt);
    chk1("xm_reg_write", xm_reg_write, cur.rw);
`ifdef MEM_STALL_CNT_EN
    chk16("mem_stall_cnt", mem_stall_cnt, exp_cnt);
`endif
    mem_op = cur.valid && (cur.rd || cur.wr);
    is_ld  = cur.rd && !cur.wr;
    eaddr  = cur.alu & 16'hFFFE;
    ewdata = cur.m2m ? exp_mw_data : cur.sd;
    if (mem_op) begin
      req_cycles++;
      ack = (req_cycles >= cur.lat);
      chk1("dmem_req", dmem_req, 1'b1);
      chk1("dmem_we", dmem_we, cur.wr);
      chk16("dmem_addr", dmem_addr, eaddr);
      if (cur.wr) chk16("dmem_wdata", dmem_wdata, ewdata);
    end else begin
      ack = 1'($urandom);
      chk1("dmem_req_idle", dmem_req, 1'b0);
    end
    dmem_ack   = ack;
    dmem_rdata = (ack && dmem_req && !dmem_we) ? env_mem[dmem_addr[7:1]] : 16'($urandom);
    #1;
    exp_stall = mem_op && !ack;
    chk1("stall_out", stall_out, exp_stall);
    if (stall_out) dut_stalls++;
`ifdef MEM_STALL_CNT_EN
    if (mem_stall_cnt_clr) exp_cnt = 16'h0;
    else if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
    if (!exp_stall) begin
      if (ack && dmem_req && dmem_we) env_mem[dmem_addr[7:1]] = dmem_wdata;
      if (mem_op && cur.wr) ref_mem[eaddr[7:1]] = ewdata;
      exp_mw_valid = cur.valid;
      exp_mw_rw    = cur.valid && cur.rw && !cur.wr;
      exp_mw_dst   = cur.dst;
      exp_mw_data  = (mem_op && is_ld) ? ref_mem[eaddr[7:1]] : cur.alu;
      req_cycles   = 0;
      cur = (prog.size() != 0) ? prog.pop_front() : bubble();
      drive(cur);
    end else begin
      drive(garbage());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_prog();
    while (prog.size() != 0 || cur.valid) cycle();
    cycle();
  endtask

  task automatic model_reset();
    cur = '{default: 0};
    exp_mw_valid = 1'b0; exp_mw_rw = 1'b0; exp_mw_dst = 4'h0; exp_mw_data = 16'h0;
    req_cycles = 0;
    exp_cnt = 16'h0;
  endtask

  initial begin
    int unsigned s0;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 16'h0;
`ifdef MEM_STALL_CNT_EN
    mem_stall_cnt_clr = 1'b0;
`endif
    drive('{default: 0});
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = 16'($urandom);
      ref_mem[i] = env_mem[i];
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_dmem_we", dmem_we, 1'b0);
    chk1("rst_stall", stall_out, 1'b0);
    chk1("rst_mw_valid", mw_valid, 1'b0);
    chk1("rst_mw_reg_write", mw_reg_write, 1'b0);
    chk16("rst_mw_data", mw_data, 16'h0);
    chk16("rst_xm_alu_out", xm_alu_out, 16'h0);
    rst = 1'b0;

    // ALU op, no memory access.
    s0 = dut_stalls;
    prog.push_back(mk(1'b0, 1'b0, 16'h1234, 16'h0, 1'b1, 4'd5, 4'd0, 1'b0, 1));
    run_prog();
    chk32("alu_no_stall", dut_stalls - s0, 0);

    // Load with ack on the 3rd request cycle from an odd address.
    env_mem[7'h20] = 16'hBEEF; ref_mem[7'h20] = 16'hBEEF;
    s0 = dut_stalls;
    prog.push_back(mk(1'b1, 1'b0, 16'h0041, 16'h0, 1'b1, 4'd2, 4'd0, 1'b0, 3));
    run_prog();
    chk32("load3_stalls", dut_stalls - s0, 2);

    // Load r3 then store r3 via M-to-M.
    env_mem[7'h30] = 16'hA5A5; ref_mem[7'h30] = 16'hA5A5;
    prog.push_back(mk(1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 4'd3, 4'd0, 1'b0, 1));
    prog.push_back(mk(1'b0, 1'b1, 16'h0071, 16'h1111, 1'b1, 4'd9, 4'd3, 1'b1, 2));
    run_prog();
    chk16("m2m_store_mem", env_mem[7'h38], 16'hA5A5);

    // Read and write both set: store.
    prog.push_back(mk(1'b1, 1'b1, 16'h0082, 16'h7777, 1'b1, 4'd4, 4'd1, 1'b0, 1));
    run_prog();
    chk16("rdwr_store_mem", env_mem[7'h41], 16'h7777);

    // Reset in the middle of a long access.
    prog.push_back(mk(1'b1, 1'b0, 16'h0090, 16'h0, 1'b1, 4'd6, 4'd0, 1'b0, 1000));
    cycle();
    cycle();
    cycle();
    chk1("pre_rst_stall", stall_out, 1'b1);
    rst = 1'b1;
    dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk1("midrst_req", dmem_req, 1'b0);
    chk1("midrst_stall", stall_out, 1'b0);
    chk1("midrst_mw_valid", mw_valid, 1'b0);
    repeat (4) cycle();

    // Random stream.
    gen_last_valid = 1'b0;
    for (int n = 0; n < 300; n++) prog.push_back(rand_instr());
    run_prog();

`ifdef MEM_STALL_CNT_EN
    mem_stall_cnt_clr = 1'b1;
    cycle();
    mem_stall_cnt_clr = 1'b0;
    for (int n = 0; n < 3; n++)
      prog.push_back(mk(1'b1, 1'b0, 16'(16 * n), 16'h0, 1'b1, 4'd1, 4'd0, 1'b0, 5));
    run_prog();
    chk16("cnt_three_loads", mem_stall_cnt, 16'd12);
    mem_stall_cnt_clr = 1'b1;
    cycle();
    mem_stall_cnt_clr = 1'b0;
    chk16("cnt_cleared", mem_stall_cnt, 16'h0);
    prog.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 4'd1, 4'd0, 1'b0, 70001));
    run_prog();
    chk16("cnt_saturated", mem_stall_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
